// File: rtl/glift_mul_arbiter.sv
// Two-requester arbiter in front of one GLIFT 4x4 array multiplier.
// The grant decision carries its own taint, which travels with the response ID.
module array_mutliplier (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] a_t,
  input  logic [3:0] b_t,
  output logic [7:0] p,
  output logic [7:0] p_t
);
  function automatic logic and_t(input logic x, input logic xt, input logic y, input logic yt);
    return (x & yt) | (y & xt) | (xt & yt);
  endfunction

  function automatic logic or_t(input logic x, input logic xt, input logic y, input logic yt);
    return (~x & yt) | (~y & xt) | (xt & yt);
  endfunction

  logic [7:0] acc, acc_t, row, row_t;
  logic c, c_t, g, g_t, x, x_t, h, h_t, s, s_t;

  // Rows of partial products are folded in with gate-level ripple adders so that
  // each gate contributes its precise GLIFT taint.
  always_comb begin
    acc = '0; acc_t = '0; row = '0; row_t = '0;
    c = 1'b0; c_t = 1'b0; g = 1'b0; g_t = 1'b0; x = 1'b0; x_t = 1'b0;
    h = 1'b0; h_t = 1'b0; s = 1'b0; s_t = 1'b0;
    for (int i = 0; i < 4; i++) begin
      acc[i]   = a[i] & b[0];
      acc_t[i] = and_t(a[i], a_t[i], b[0], b_t[0]);
    end
    for (int j = 1; j < 4; j++) begin
      row = '0; row_t = '0;
      for (int i = 0; i < 4; i++) begin
        row[i+j]   = a[i] & b[j];
        row_t[i+j] = and_t(a[i], a_t[i], b[j], b_t[j]);
      end
      c = 1'b0; c_t = 1'b0;
      for (int k = 0; k < 8; k++) begin
        g = acc[k] & row[k];  g_t = and_t(acc[k], acc_t[k], row[k], row_t[k]);
        x = acc[k] ^ row[k];  x_t = acc_t[k] | row_t[k];
        h = c & x;            h_t = and_t(c, c_t, x, x_t);
        s = x ^ c;            s_t = x_t | c_t;
        acc[k] = s;  acc_t[k] = s_t;
        c = g | h;   c_t = or_t(g, g_t, h, h_t);
      end
    end
    p   = acc;
    p_t = acc_t;
  end
endmodule

module glift_mul_arbiter #(
  parameter bit PRIO_MODE   = 1'b0,
  parameter bit TAINT_VALID = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  input  logic [1:0] req_valid_t,
  output logic [1:0] req_ready,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic [7:0] req_a_t,
  input  logic [7:0] req_b_t,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_id,
  output logic       resp_id_t,
  output logic [7:0] resp_p,
  output logic [7:0] resp_p_t,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  state_t     state_reg;
  logic       ptr_reg, ptr_t_reg;
  logic [3:0] op_a_reg, op_b_reg, op_a_t_reg, op_b_t_reg;
  logic       id_reg, id_t_reg;
  logic [7:0] p_reg, p_t_reg;
  logic       any_valid, gnt_id, gnt_id_t;
  logic [7:0] mul_p, mul_p_t;

  array_mutliplier u_mul (
    .a   (op_a_reg),
    .b   (op_b_reg),
    .a_t (op_a_t_reg),
    .b_t (op_b_t_reg),
    .p   (mul_p),
    .p_t (mul_p_t)
  );

  always_comb begin
    any_valid = |req_valid;
    if (&req_valid) gnt_id = PRIO_MODE ? 1'b0 : ~ptr_reg;
    else            gnt_id = req_valid[1];
    // Request timing taints the decision only when valid taints are honoured.
    gnt_id_t = ptr_t_reg | (TAINT_VALID & (|req_valid_t));
    req_ready = 2'b00;
    if (state_reg == IDLE && any_valid) req_ready[gnt_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      ptr_reg    <= 1'b0;
      ptr_t_reg  <= 1'b0;
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      op_a_t_reg <= '0;
      op_b_t_reg <= '0;
      id_reg     <= 1'b0;
      id_t_reg   <= 1'b0;
      p_reg      <= '0;
      p_t_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: if (any_valid) begin
          op_a_reg   <= gnt_id ? req_a[7:4]   : req_a[3:0];
          op_b_reg   <= gnt_id ? req_b[7:4]   : req_b[3:0];
          op_a_t_reg <= gnt_id ? req_a_t[7:4] : req_a_t[3:0];
          op_b_t_reg <= gnt_id ? req_b_t[7:4] : req_b_t[3:0];
          id_reg     <= gnt_id;
          id_t_reg   <= gnt_id_t;
          if (!PRIO_MODE) begin
            ptr_reg   <= gnt_id;
            ptr_t_reg <= gnt_id_t;
          end
          state_reg <= MUL;
        end
        MUL: begin
          p_reg     <= mul_p;
          p_t_reg   <= mul_p_t;
          state_reg <= RESP;
        end
        RESP: if (resp_ready) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign resp_valid = (state_reg == RESP);
  assign busy       = (state_reg != IDLE);
  assign resp_id    = id_reg;
  assign resp_id_t  = id_t_reg;
  assign resp_p     = p_reg;
  assign resp_p_t   = p_t_reg;
endmodule

// File: tb/tb_glift_mul_arbiter.sv
// Directed bench: instance 0 round-robin, 1 fixed priority, 2 round-robin ignoring valid taints.
// All three share stimulus so their transactions run in lockstep.
module tb_glift_mul_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid, req_valid_t;
  logic [7:0] req_a, req_b, req_a_t, req_b_t;
  logic       resp_ready;

  logic [1:0] rdy  [3];
  logic       rv   [3];
  logic       id   [3];
  logic       idt  [3];
  logic [7:0] p    [3];
  logic [7:0] pt   [3];
  logic       busy [3];

  logic [1:0] got_rdy [3];
  logic       got_id  [3];
  logic       got_idt [3];
  logic [7:0] got_p   [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    glift_mul_arbiter #(
      .PRIO_MODE   (gi == 1),
      .TAINT_VALID (gi != 2)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_valid_t (req_valid_t),
      .req_ready   (rdy[gi]),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_a_t     (req_a_t),
      .req_b_t     (req_b_t),
      .resp_valid  (rv[gi]),
      .resp_ready  (resp_ready),
      .resp_id     (id[gi]),
      .resp_id_t   (idt[gi]),
      .resp_p      (p[gi]),
      .resp_p_t    (pt[gi]),
      .busy        (busy[gi])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, got);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; req_valid_t = '0; resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Starts at a negedge with the DUTs idle; returns at a negedge with them idle again.
  task automatic op(input logic [1:0] v, input logic [1:0] vt, input logic [7:0] a,
                    input logic [7:0] b, input logic [7:0] at, input logic [7:0] bt,
                    input int stall, input logic [7:0] ep, input logic [7:0] ept);
    req_valid = v; req_valid_t = vt; req_a = a; req_b = b;
    req_a_t = at; req_b_t = bt; resp_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) got_rdy[i] = rdy[i];
    @(negedge clk);
    req_valid = '0; req_valid_t = '0;
    check("busy_mul", busy[0], 1);
    check("rv_mul", rv[0], 0);
    @(negedge clk);
    check("rv_resp", rv[0], 1);
    check("p", p[0], ep);
    check("p_t", pt[0], ept);
    for (int s = 0; s < stall; s++) begin
      req_valid = v;
      @(negedge clk);
      check("rdy_stall", rdy[0], 0);
      check("rv_stall", rv[0], 1);
      check("busy_stall", busy[0], 1);
      check("p_stall", p[0], ep);
    end
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      got_id[i] = id[i]; got_idt[i] = idt[i]; got_p[i] = p[i];
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("rv_done", rv[0], 0);
    check("busy_done", busy[0], 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rr_ids [4]  = '{2'd1, 2'd0, 2'd1, 2'd0};
    logic [7:0] rr_p   [4]  = '{8'd28, 8'd9, 8'd42, 8'd15};
    logic [7:0] fx_p   [4]  = '{8'd6, 8'd9, 8'd12, 8'd15};
    logic [3:0] a0, b0, b1;

    req_a = '0; req_b = '0; req_a_t = '0; req_b_t = '0;
    do_reset();
    #1;
    check("rst_ready", rdy[0], 0);
    check("rst_rv", rv[0], 0);
    check("rst_id", id[0], 0);
    check("rst_id_t", idt[0], 0);
    check("rst_p", p[0], 0);
    check("rst_p_t", pt[0], 0);
    check("rst_busy", busy[0], 0);
    @(negedge clk);

    // Simple single request from requester 0.
    op(2'b01, 2'b00, 8'h03, 8'h05, 8'h00, 8'h00, 0, 8'd15, 8'h00);
    check("t1_ready", got_rdy[0], 2'b01);
    check("t1_id", got_id[0], 0);
    check("t1_id_t", got_idt[0], 0);

    // Max operands with 5 cycles of backpressure.
    op(2'b10, 2'b00, 8'hF0, 8'hF0, 8'h00, 8'h00, 5, 8'd225, 8'h00);
    check("t2_ready", got_rdy[0], 2'b10);
    check("t2_id", got_id[0], 1);

    // Both valid for four ops after reset.
    do_reset();
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      a0 = 4'(2 + k); b0 = 4'd3; b1 = 4'(4 + k);
      op(2'b11, 2'b00, {4'd7, a0}, {b1, b0}, 8'h00, 8'h00, 0, rr_p[k], 8'h00);
      check("rr_ready", got_rdy[0], rr_ids[k][0] ? 2'b10 : 2'b01);
      check("rr_id", got_id[0], rr_ids[k][0]);
      check("fx_ready", got_rdy[1], 2'b01);
      check("fx_id", got_id[1], 0);
      check("fx_p", got_p[1], fx_p[k]);
    end

    // Tainted operand against untainted zero, then against untainted one.
    op(2'b01, 2'b00, 8'h09, 8'h00, 8'h0F, 8'h00, 0, 8'd0, 8'h00);
    op(2'b01, 2'b00, 8'h05, 8'h01, 8'h0F, 8'h00, 0, 8'd5, 8'h0F);

    // Grant taint from valid taints, then sticking through the pointer.
    do_reset();
    @(negedge clk);
    op(2'b11, 2'b10, 8'h21, 8'h31, 8'h00, 8'h00, 0, 8'd6, 8'h00);
    check("t5_id", got_id[0], 1);
    check("t5_id_t", got_idt[0], 1);
    check("t5_fx_id_t", got_idt[1], 1);
    check("t5_tv0_id_t", got_idt[2], 0);
    op(2'b01, 2'b00, 8'h04, 8'h05, 8'h00, 8'h00, 0, 8'd20, 8'h00);
    check("t5b_id", got_id[0], 0);
    check("t5b_id_t", got_idt[0], 1);
    check("t5b_fx_id_t", got_idt[1], 0);
    check("t5b_tv0_id_t", got_idt[2], 0);

    // Reset during MUL: grant went to requester 1, which must be forgotten.
    req_valid = 2'b11; req_a = 8'h22; req_b = 8'h22;
    @(negedge clk);
    req_valid = '0;
    check("t6_busy_mul", busy[0], 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_rv_rst", rv[0], 0);
    check("t6_busy_rst", busy[0], 0);
    check("t6_p_rst", p[0], 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_no_resp", rv[0], 0);
    end
    op(2'b11, 2'b00, 8'h62, 8'h73, 8'h00, 8'h00, 0, 8'd42, 8'h00);
    check("t6_id", got_id[0], 1);
    check("t6_id_t", got_idt[0], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
